// File: rtl/lv_err_mgr_if.sv
// Bundle between lv_err_mgr and its error sources / register block / lv_ctrl_fsm.
// master drives raw errors, mask, class and clears; slave is the error manager.
interface lv_err_mgr_if #(
    parameter int unsigned ERR_NUM = 16,
    parameter int unsigned ID_W    = $clog2(ERR_NUM)
);
    logic [ERR_NUM-1:0] i_err_raw;
    logic [ERR_NUM-1:0] i_err_mask;
    logic [ERR_NUM-1:0] i_err_fatal;
    logic               i_clr_vld;
    logic [ERR_NUM-1:0] i_clr_bits;
    logic [ERR_NUM-1:0] o_err_sts;
    logic [ID_W-1:0]    o_err_id;
    logic               o_err_id_vld;
    logic               o_fault_req;
    logic               o_warn_req;
    logic               o_int_n;

    modport master (
        output i_err_raw, i_err_mask, i_err_fatal, i_clr_vld, i_clr_bits,
        input  o_err_sts, o_err_id, o_err_id_vld, o_fault_req, o_warn_req, o_int_n
    );

    modport slave (
        input  i_err_raw, i_err_mask, i_err_fatal, i_clr_vld, i_clr_bits,
        output o_err_sts, o_err_id, o_err_id_vld, o_fault_req, o_warn_req, o_int_n
    );
endinterface

// File: rtl/lv_err_mgr.sv
// LV die error manager: per-source debounce, sticky W1C status, fault/warning split,
// priority error ID and interrupt pulse scheduler. Debounce is built only with LV_ERR_DBNC_EN.
module lv_err_mgr #(
    parameter int unsigned ERR_NUM  = 16,
    parameter int unsigned DBNC_CYC = 4,
    parameter int unsigned DBNC_W   = 3,
    parameter int unsigned INT_PW   = 8,
    parameter int unsigned ID_W     = $clog2(ERR_NUM)
) (
    input logic         i_clk,
    input logic         i_rst,
    lv_err_mgr_if.slave bus
);
    localparam int unsigned PW_W = (INT_PW > 1) ? $clog2(INT_PW) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} intState_e;

    if (INT_PW < 1 || DBNC_CYC < 1 || DBNC_CYC > (2 ** DBNC_W) - 1) begin : g_param_chk
        $error("lv_err_mgr: INT_PW or DBNC_CYC out of range");
    end

    logic [ERR_NUM-1:0] setVec;
    logic [ERR_NUM-1:0] clrVec;
    logic [ERR_NUM-1:0] pending;
    logic               newEvent;

    logic [ERR_NUM-1:0] sts_q, sts_d;
    logic [ERR_NUM-1:0] pendPrev_q;
    logic               faultReq_q, faultReq_d;
    logic               warnReq_q, warnReq_d;
    logic               errIdVld_q, errIdVld_d;
    logic [ID_W-1:0]    errId_q, errId_d;
    intState_e          state_q, state_d;
    logic [PW_W-1:0]    pwCnt_q, pwCnt_d;
    logic               flag_q, flag_d;

`ifdef LV_ERR_DBNC_EN
    logic [DBNC_W-1:0] dbncCnt_q [ERR_NUM];
    logic [DBNC_W-1:0] dbncCnt_d [ERR_NUM];

    // Set fires once per high run, on the cycle the counter reaches DBNC_CYC-1.
    always_comb begin
        for (int i = 0; i < int'(ERR_NUM); i++) begin
            dbncCnt_d[i] = '0;
            setVec[i]    = 1'b0;
            if (bus.i_err_raw[i]) begin
                dbncCnt_d[i] = (dbncCnt_q[i] == DBNC_W'(DBNC_CYC)) ? dbncCnt_q[i]
                                                                   : dbncCnt_q[i] + DBNC_W'(1);
                setVec[i]    = (dbncCnt_q[i] == DBNC_W'(DBNC_CYC - 1));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(ERR_NUM); i++) begin
            if (i_rst) begin
                dbncCnt_q[i] <= '0;
            end else begin
                dbncCnt_q[i] <= dbncCnt_d[i];
            end
        end
    end
`else
    assign setVec = bus.i_err_raw;
`endif

    assign clrVec   = bus.i_clr_vld ? bus.i_clr_bits : '0;
    assign pending  = sts_q & ~bus.i_err_mask;
    assign newEvent = |(pending & ~pendPrev_q);

    // Set wins over a same-cycle clear; the ID holds its last value when nothing is pending.
    always_comb begin
        sts_d      = (sts_q & ~clrVec) | setVec;
        faultReq_d = |(pending & bus.i_err_fatal);
        warnReq_d  = |(pending & ~bus.i_err_fatal);
        errIdVld_d = |pending;
        errId_d    = errId_q;
        for (int i = int'(ERR_NUM) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                errId_d = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pwCnt_d = pwCnt_q;
        flag_d  = flag_q;
        case (state_q)
            ST_IDLE: begin
                if (newEvent) begin
                    state_d = ST_PULSE;
                    pwCnt_d = PW_W'(INT_PW - 1);
                end
            end
            ST_PULSE: begin
                if (newEvent) begin
                    flag_d = 1'b1;
                end
                if (pwCnt_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    pwCnt_d = pwCnt_q - PW_W'(1);
                end
            end
            ST_GAP: begin
                flag_d = 1'b0;
                if (flag_q || newEvent) begin
                    state_d = ST_PULSE;
                    pwCnt_d = PW_W'(INT_PW - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sts_q      <= '0;
            pendPrev_q <= '0;
            faultReq_q <= 1'b0;
            warnReq_q  <= 1'b0;
            errIdVld_q <= 1'b0;
            errId_q    <= '0;
            state_q    <= ST_IDLE;
            pwCnt_q    <= '0;
            flag_q     <= 1'b0;
        end else begin
            sts_q      <= sts_d;
            pendPrev_q <= pending;
            faultReq_q <= faultReq_d;
            warnReq_q  <= warnReq_d;
            errIdVld_q <= errIdVld_d;
            errId_q    <= errId_d;
            state_q    <= state_d;
            pwCnt_q    <= pwCnt_d;
            flag_q     <= flag_d;
        end
    end

    assign bus.o_err_sts    = sts_q;
    assign bus.o_err_id     = errId_q;
    assign bus.o_err_id_vld = errIdVld_q;
    assign bus.o_fault_req  = faultReq_q;
    assign bus.o_warn_req   = warnReq_q;
    assign bus.o_int_n      = (state_q != ST_PULSE);
endmodule
